// File: rtl/f_fetch_unit.sv
// Fetch stage and F/D pipeline register of the 5-stage MIPS core.
// Holds the fetch PC and picks the next PC from the D-stage branch/jump decision.
module f_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] F_instr,
   input  logic [2:0]  D_npc_sel,
   input  logic        D_equal,
   input  logic [15:0] D_imm16,
   input  logic [25:0] D_imm26,
   input  logic [31:0] D_rs_data,
   output logic [31:0] F_PC,
   output logic [31:0] D_PC,
   output logic [31:0] D_instr
);

   typedef enum logic [2:0] {
      NPC_PC4    = 3'b000,
      NPC_BRANCH = 3'b001,
      NPC_JUMP   = 3'b010,
      NPC_JR     = 3'b011
   } npc_sel_e;

   logic [31:0] f_pc_q, f_pc_d;
   logic [31:0] d_pc_q, d_pc_d;
   logic [31:0] d_instr_q, d_instr_d;

   logic [31:0] pc4;
   logic [31:0] btgt;
   logic [31:0] jtgt;
   logic [31:0] boff;

   // Targets are relative to the instruction in D; the delay slot is already at F_PC.
   assign pc4  = f_pc_q + 32'd4;
   assign boff = {{14{D_imm16[15]}}, D_imm16, 2'b00};
   assign btgt = d_pc_q + 32'd4 + boff;
   assign jtgt = {d_pc_q[31:28], D_imm26, 2'b00};

   // NOTE: every output of a combinational block gets a default assignment first,
   // so no path through the case statement can leave a value unassigned (latch).
   always_comb begin
      f_pc_d    = pc4;
      d_pc_d    = f_pc_q;
      d_instr_d = F_instr;
      case (D_npc_sel)
         NPC_BRANCH: f_pc_d = D_equal ? btgt : pc4;
         NPC_JUMP:   f_pc_d = jtgt;
         NPC_JR:     f_pc_d = D_rs_data;
         default:    f_pc_d = pc4;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all three registers
   // update from the same pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc_q    <= RESET_PC;
         d_pc_q    <= RESET_PC;
         d_instr_q <= NOP_INSTR;
      end else if (!stall) begin
         f_pc_q    <= f_pc_d;
         d_pc_q    <= d_pc_d;
         d_instr_q <= d_instr_d;
      end
   end

   assign F_PC    = f_pc_q;
   assign D_PC    = d_pc_q;
   assign D_instr = d_instr_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed spec scenarios followed by
// random stimulus, compared against a behavioural PC/pipeline model.
module tb_f_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] F_instr;
   logic [2:0]  D_npc_sel;
   logic        D_equal;
   logic [15:0] D_imm16;
   logic [25:0] D_imm26;
   logic [31:0] D_rs_data;
   logic [31:0] F_PC;
   logic [31:0] D_PC;
   logic [31:0] D_instr;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: what the fetch PC, D-stage PC and D-stage instruction should be
   logic [31:0] m_f_pc;
   logic [31:0] m_d_pc;
   logic [31:0] m_d_instr;

   always #5 clk = ~clk;

   f_fetch_unit dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .F_instr   (F_instr),
      .D_npc_sel (D_npc_sel),
      .D_equal   (D_equal),
      .D_imm16   (D_imm16),
      .D_imm26   (D_imm26),
      .D_rs_data (D_rs_data),
      .F_PC      (F_PC),
      .D_PC      (D_PC),
      .D_instr   (D_instr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Next fetch address from the architectural rules, using signed integer arithmetic.
   function automatic logic [31:0] model_npc(input logic [2:0] sel, input logic eq,
                                             input logic [15:0] i16, input logic [25:0] i26,
                                             input logic [31:0] rs);
      longint signed off;
      longint signed tgt;
      off = longint'($signed(i16)) * 4;
      if (sel == 3'd1 && eq) begin
         tgt = longint'(m_d_pc) + 4 + off;
         return tgt[31:0];
      end
      if (sel == 3'd2) return (m_d_pc & 32'hF000_0000) | (32'(i26) * 4);
      if (sel == 3'd3) return rs;
      return 32'((longint'(m_f_pc) + 4) % 64'h1_0000_0000);
   endfunction

   task automatic step(input logic rst, input logic stl, input logic [2:0] sel, input logic eq,
                       input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs,
                       input logic [31:0] instr, input string tag);
      logic [31:0] nf, nd, ni;
      reset = rst; stall = stl; D_npc_sel = sel; D_equal = eq;
      D_imm16 = i16; D_imm26 = i26; D_rs_data = rs; F_instr = instr;
      if (rst) begin
         nf = 32'h0000_3000; nd = 32'h0000_3000; ni = 32'h0;
      end else if (stl) begin
         nf = m_f_pc; nd = m_d_pc; ni = m_d_instr;
      end else begin
         nf = model_npc(sel, eq, i16, i26, rs); nd = m_f_pc; ni = instr;
      end
      @(posedge clk);
      m_f_pc = nf; m_d_pc = nd; m_d_instr = ni;
      #1;
      check({tag, ".F_PC"}, F_PC, m_f_pc);
      check({tag, ".D_PC"}, D_PC, m_d_pc);
      check({tag, ".D_instr"}, D_instr, m_d_instr);
   endtask

   task automatic seq(input logic [31:0] instr, input string tag);
      step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, instr, tag);
   endtask

   task automatic do_reset(input string tag);
      step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'hDEAD_BEEF, tag);
   endtask

   initial begin
      m_f_pc = 32'hx; m_d_pc = 32'hx; m_d_instr = 32'hx;

      // reset for two cycles, then the first sequential fetch
      do_reset("rst0");
      do_reset("rst1");
      check("rst_fpc_const", F_PC, 32'h0000_3000);
      check("rst_dinstr_const", D_instr, 32'h0);
      seq(32'h2408_0001, "seq0");
      check("seq0_dinstr_const", D_instr, 32'h2408_0001);
      check("seq0_fpc_const", F_PC, 32'h0000_3004);

      // beq taken with negative offset: D_PC=0x3008
      seq(32'h1111_0000, "seq1");
      seq(32'h1000_FFFE, "seq2");
      check("beq_setup_dpc", D_PC, 32'h0000_3008);
      step(1'b0, 1'b0, 3'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'h2222_0000, "beq_t");
      check("beq_taken_const", F_PC, 32'h0000_3004);

      // beq not taken
      do_reset("rst2");
      seq(32'h1, "s"); seq(32'h2, "s"); seq(32'h3, "s");
      step(1'b0, 1'b0, 3'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h4, "beq_nt");
      check("beq_ntaken_const", F_PC, 32'h0000_3010);

      // j and jr from D_PC=0x3010
      do_reset("rst3");
      for (int i = 0; i < 5; i++) seq(32'h100 + 32'(i), "walk");
      check("j_setup_dpc", D_PC, 32'h0000_3010);
      step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h000_0C10, 32'h0, 32'h55, "j");
      check("j_const", F_PC, 32'h0000_3040);
      step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3100, 32'h66, "jr");
      check("jr_const", F_PC, 32'h0000_3100);
      step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3101, 32'h77, "jr_mis");
      check("jr_misaligned_const", F_PC, 32'h0000_3101);
      step(1'b0, 1'b0, 3'd5, 1'b1, 16'h7FFF, 26'h3FF_FFFF, 32'h0, 32'h88, "sel_other");

      // stall three cycles with a taken branch pending, then release
      do_reset("rst4");
      seq(32'h10, "s"); seq(32'h11, "s"); seq(32'h12, "s");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 3'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 32'h99, "stall");
      check("stall_fpc_const", F_PC, 32'h0000_300C);
      step(1'b0, 1'b0, 3'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 32'h13, "stall_rel");
      check("stall_rel_const", F_PC, 32'h0000_304C);
      seq(32'h14, "after_rel");
      check("after_rel_const", F_PC, 32'h0000_3050);

      // reset beats stall and a pending jump
      step(1'b1, 1'b1, 3'd2, 1'b1, 16'h0, 26'h3FF_FFFF, 32'h0, 32'hABCD, "rst_stall");
      check("rst_stall_const", F_PC, 32'h0000_3000);

      // wrap: jr to 0xFFFFFFFC then PC+4
      step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h1, "to_top");
      seq(32'h2, "wrap");
      check("wrap_const", F_PC, 32'h0000_0000);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 26'($urandom),
              $urandom, $urandom, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
